// File: rtl/rs_issue_select.sv
// Reservation-station issue select: oldest-ready grant per FU, divider busy tracking.
// Optional ISSUE_SEL_PERF_CNT_EN adds per-FU grant counters on perf_issue_cnt.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 8
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 6
`endif

module rs_issue_select #(
    parameter int RS_NUM         = 8,
    parameter int ISSUE_W        = `ISSUE_WIDTH,
    parameter int UNPIPE_FU_ID   = 5,
    parameter int UNPIPE_LATENCY = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_flush,
    input  logic [ISSUE_W-1:0]          rs_wake_up     [RS_NUM],
    input  logic [`ROB_WIDTH:0]         rs_age         [RS_NUM],
    input  logic [`PRF_WIDTH-1:0]       rs_dest_prn    [RS_NUM],
    input  logic [ISSUE_W-1:0]          fu_stall,
    output logic [RS_NUM-1:0]           issue_en,
    output logic [ISSUE_W-1:0]          issue_valid,
    output logic [$clog2(RS_NUM)-1:0]   issue_idx      [ISSUE_W],
    output logic [`PRF_WIDTH-1:0]       issue_dest_prn [ISSUE_W],
`ifdef ISSUE_SEL_PERF_CNT_EN
    output logic [31:0]                 perf_issue_cnt [ISSUE_W],
`endif
    output logic                        unpipe_busy
);

    localparam int ROB_W = `ROB_WIDTH;
    localparam int IDX_W = $clog2(RS_NUM);
    localparam int CNT_W = $clog2(UNPIPE_LATENCY + 1);

    logic [CNT_W-1:0] busy_cnt;

    // ROB tags wrap; a differing wrap bit means the numerically larger low part is older.
    function automatic logic is_older(input logic [ROB_W:0] a, input logic [ROB_W:0] b);
        if (a[ROB_W] == b[ROB_W])
            return a[ROB_W-1:0] < b[ROB_W-1:0];
        else
            return a[ROB_W-1:0] > b[ROB_W-1:0];
    endfunction

    assign unpipe_busy = (busy_cnt != '0);

    always_comb begin : select_comb
        logic             found;
        logic [IDX_W-1:0] best;
        issue_en    = '0;
        issue_valid = '0;
        found       = 1'b0;
        best        = '0;
        for (int f = 0; f < ISSUE_W; f++) begin
            issue_idx[f]      = '0;
            issue_dest_prn[f] = '0;
        end
        for (int f = 0; f < ISSUE_W; f++) begin
            // NOTE: found/best are scratch variables reused per FU; blocking '=' is what
            // makes the scan see its own earlier iterations.
            found = 1'b0;
            best  = '0;
            for (int e = 0; e < RS_NUM; e++) begin
                if (rs_wake_up[e][f] && (!found || is_older(rs_age[e], rs_age[best]))) begin
                    found = 1'b1;
                    best  = IDX_W'(e);
                end
            end
            if (found && !fu_stall[f] && !pipe_flush && !(f == UNPIPE_FU_ID && unpipe_busy)) begin
                issue_valid[f]    = 1'b1;
                issue_idx[f]      = best;
                issue_dest_prn[f] = rs_dest_prn[best];
                issue_en[best]    = 1'b1;
            end
        end
    end

    // Flush wins over a same-cycle load; a grant only happens when the counter is already idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
            busy_cnt <= '0;
        end else if (pipe_flush) begin
            busy_cnt <= '0;
        end else if (issue_valid[UNPIPE_FU_ID]) begin
            busy_cnt <= CNT_W'(UNPIPE_LATENCY);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
        end
    end

`ifdef ISSUE_SEL_PERF_CNT_EN
    // Counters deliberately survive pipe_flush and wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < ISSUE_W; f++) perf_issue_cnt[f] <= '0;
        end else begin
            for (int f = 0; f < ISSUE_W; f++)
                perf_issue_cnt[f] <= perf_issue_cnt[f] + 32'(issue_valid[f]);
        end
    end
`endif

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: age order, wrap, divider busy, stall, flush, async reset.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 8
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 6
`endif

module tb_rs_issue_select;

    localparam int RS_NUM  = 8;
    localparam int ISSUE_W = `ISSUE_WIDTH;
    localparam int ROB_W   = `ROB_WIDTH;
    localparam int PRF_W   = `PRF_WIDTH;
    localparam int IDX_W   = $clog2(RS_NUM);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 pipe_flush;
    logic [ISSUE_W-1:0]   rs_wake_up     [RS_NUM];
    logic [ROB_W:0]       rs_age         [RS_NUM];
    logic [PRF_W-1:0]     rs_dest_prn    [RS_NUM];
    logic [ISSUE_W-1:0]   fu_stall;
    logic [RS_NUM-1:0]    issue_en;
    logic [ISSUE_W-1:0]   issue_valid;
    logic [IDX_W-1:0]     issue_idx      [ISSUE_W];
    logic [PRF_W-1:0]     issue_dest_prn [ISSUE_W];
    logic                 unpipe_busy;
`ifdef ISSUE_SEL_PERF_CNT_EN
    logic [31:0]          perf_issue_cnt [ISSUE_W];
`endif

    int n_checks = 0;
    int n_fails  = 0;

    rs_issue_select #(.RS_NUM(RS_NUM), .ISSUE_W(ISSUE_W), .UNPIPE_FU_ID(5), .UNPIPE_LATENCY(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_flush     (pipe_flush),
        .rs_wake_up     (rs_wake_up),
        .rs_age         (rs_age),
        .rs_dest_prn    (rs_dest_prn),
        .fu_stall       (fu_stall),
        .issue_en       (issue_en),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .issue_dest_prn (issue_dest_prn),
`ifdef ISSUE_SEL_PERF_CNT_EN
        .perf_issue_cnt (perf_issue_cnt),
`endif
        .unpipe_busy    (unpipe_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        for (int e = 0; e < RS_NUM; e++) begin
            rs_wake_up[e]  = '0;
            rs_age[e]      = '0;
            rs_dest_prn[e] = '0;
        end
        fu_stall   = '0;
        pipe_flush = 1'b0;
    endtask

    task automatic wake(input int e, input int fu, input logic [ROB_W:0] age, input logic [PRF_W-1:0] prn);
        rs_wake_up[e]     = '0;
        rs_wake_up[e][fu] = 1'b1;
        rs_age[e]         = age;
        rs_dest_prn[e]    = prn;
    endtask

    task automatic unwake(input int e);
        rs_wake_up[e] = '0;
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        #2;
        check("reset_issue_en", 64'(issue_en), 64'h0);
        check("reset_issue_valid", 64'(issue_valid), 64'h0);
        check("reset_busy", 64'(unpipe_busy), 64'h0);
        check("reset_idx0", 64'(issue_idx[0]), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Oldest-first on FU0: e1 (age 3) then e0 (age 5).
        wake(0, 0, 6'd5, 6'd10);
        wake(1, 0, 6'd3, 6'd11);
        wake(2, 0, 6'd7, 6'd12);
        #1;
        check("age_en", 64'(issue_en), 64'h02);
        check("age_idx", 64'(issue_idx[0]), 64'd1);
        check("age_prn", 64'(issue_dest_prn[0]), 64'd11);
        check("age_valid", 64'(issue_valid), 64'h01);
        check("age_idx_unused_fu", 64'(issue_idx[3]), 64'h0);
        tick();
        unwake(1);
        #1;
        check("age_next_en", 64'(issue_en), 64'h01);
        check("age_next_idx", 64'(issue_idx[0]), 64'd0);
        tick();
        clear_in();

        // Wrap: e1 {0,30} is older than e0 {1,2}.
        wake(0, 1, {1'b1, 5'd2}, 6'd20);
        wake(1, 1, {1'b0, 5'd30}, 6'd21);
        // Equal ages on FU2: lower index wins.
        wake(5, 2, 6'd9, 6'd25);
        wake(3, 2, 6'd9, 6'd23);
        #1;
        check("wrap_idx", 64'(issue_idx[1]), 64'd1);
        check("wrap_prn", 64'(issue_dest_prn[1]), 64'd21);
        check("tie_idx", 64'(issue_idx[2]), 64'd3);
        check("wrap_tie_en", 64'(issue_en), 64'h0A);
        tick();
        clear_in();

        // Divider: grant in cycle 0, busy for cycles 1..8, next grant once idle.
        do_reset();
        wake(4, 5, 6'd1, 6'd34);
        wake(1, 0, 6'd2, 6'd31);
        #1;
        check("div0_en", 64'(issue_en), 64'h12);
        check("div0_valid", 64'(issue_valid), 64'h21);
        check("div0_busy", 64'(unpipe_busy), 64'h0);
        tick();
        unwake(4);
        wake(6, 5, 6'd3, 6'd36);
        for (int c = 1; c <= 8; c++) begin
            #1;
            check($sformatf("div_busy_c%0d", c), 64'(unpipe_busy), 64'h1);
            check($sformatf("div_blocked_c%0d", c), 64'(issue_en), 64'h02);
            tick();
        end
        #1;
        check("div2_busy", 64'(unpipe_busy), 64'h0);
        check("div2_en", 64'(issue_en), 64'h42);
        check("div2_idx", 64'(issue_idx[5]), 64'd6);
        check("div2_prn", 64'(issue_dest_prn[5]), 64'd36);
        tick();
        unwake(6);
        #1;
        check("div2_busy_after", 64'(unpipe_busy), 64'h1);
        tick();

        // fu_stall on FU6 blocks only FU6.
        do_reset();
        wake(2, 6, 6'd4, 6'd42);
        wake(3, 0, 6'd5, 6'd43);
        fu_stall = ISSUE_W'(1) << 6;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall_en_c%0d", c), 64'(issue_en), 64'h08);
            check($sformatf("stall_valid_c%0d", c), 64'(issue_valid), 64'h01);
            tick();
        end
        fu_stall = '0;
        #1;
        check("stall_rel_en", 64'(issue_en), 64'h0C);
        check("stall_rel_idx", 64'(issue_idx[6]), 64'd2);
        tick();

        // Flush at busy count 4.
        do_reset();
        wake(7, 5, 6'd1, 6'd47);
        #1;
        check("flush_div_en", 64'(issue_en), 64'h80);
        tick();
        unwake(7);
        repeat (4) tick();
        wake(0, 0, 6'd2, 6'd50);
        wake(1, 1, 6'd3, 6'd51);
        wake(2, 5, 6'd4, 6'd52);
        pipe_flush = 1'b1;
        #1;
        check("flush_en", 64'(issue_en), 64'h0);
        check("flush_valid", 64'(issue_valid), 64'h0);
        check("flush_busy_pre", 64'(unpipe_busy), 64'h1);
        check("flush_prn0", 64'(issue_dest_prn[0]), 64'h0);
        tick();
        pipe_flush = 1'b0;
        #1;
        check("flush_busy_post", 64'(unpipe_busy), 64'h0);
        check("flush_post_en", 64'(issue_en), 64'h07);
        tick();
        clear_in();

        // Async reset mid-busy, then same-cycle issue after release.
        do_reset();
        wake(3, 5, 6'd1, 6'd53);
        tick();
        unwake(3);
        repeat (2) tick();
        #1;
        check("rst_busy_pre", 64'(unpipe_busy), 64'h1);
        rst_n = 1'b0;
        clear_in();
        #1;
        check("rst_async_busy", 64'(unpipe_busy), 64'h0);
        check("rst_async_en", 64'(issue_en), 64'h0);
        check("rst_async_valid", 64'(issue_valid), 64'h0);
        tick();
        rst_n = 1'b1;
        #1;
        wake(5, 3, 6'd6, 6'd55);
        wake(4, 5, 6'd7, 6'd54);
        #1;
        check("rst_rel_en", 64'(issue_en), 64'h30);
        check("rst_rel_prn", 64'(issue_dest_prn[3]), 64'd55);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
